// File: rtl/baud_tick_nco.sv
// rtl/baud_tick_nco.sv - phase-accumulator baud generator with oversample, mid-bit and bit ticks
// Runtime increment changes are staged and take effect only at a bit boundary or a phase clear.
module baud_tick_nco #(
  parameter int          ACC_W       = 24,
  parameter int          OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_INC = 214748
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             inc_busy,
  output logic             inc_ack,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             baud_clk
);

  localparam int               OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  MID_CNT = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  END_CNT = OS_W'(OVERSAMPLE - 1);
  localparam logic [ACC_W-1:0] RST_INC = ACC_W'(DEFAULT_INC);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] inc_pend;
  logic [OS_W-1:0]  os_cnt;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             run;
  logic             at_mid;
  logic             at_end;
  logic             apply_inc;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, inc};
    carry     = sum[ACC_W];
    run       = enable && !restart;
    at_mid    = carry && (os_cnt == MID_CNT);
    at_end    = carry && (os_cnt == END_CNT);
    // a staged increment lands on the bit boundary or on any phase clear
    apply_inc = inc_busy && (!run || at_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      inc      <= RST_INC;
      inc_pend <= '0;
      os_cnt   <= '0;
      inc_busy <= 1'b0;
      inc_ack  <= 1'b0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else begin
      inc_ack <= 1'b0;
      if (!enable) begin
        acc      <= '0;
        os_cnt   <= '0;
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
        baud_clk <= 1'b0;
      end else if (restart) begin
        acc      <= '0;
        os_cnt   <= '0;
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end else begin
        acc      <= sum[ACC_W-1:0];
        os_tick  <= carry;
        mid_tick <= at_mid;
        bit_tick <= at_end;
        if (carry) begin
          os_cnt <= os_cnt + 1'b1;
        end
        if (at_end) begin
          baud_clk <= ~baud_clk;
        end
      end

      if (apply_inc) begin
        inc      <= inc_pend;
        inc_busy <= 1'b0;
        inc_ack  <= 1'b1;
      end else if (inc_load && !inc_busy) begin
        inc_pend <= inc_in;
        inc_busy <= 1'b1;
      end
    end
  end

endmodule
